tap_master_ctrl: RTL and testbench
==================================

// Module: tap_master_ctrl
// PURPOSE
//  Synthesisable, parametrised TAP master sequencer driving the tdi/tck/trstb test port from the system clock.
//  Accepts commands over a valid/ready interface: RESET, SETKEY, ENTER (ATPG entry) and RAW shift.
//  Each command becomes a bit-serial sequence, MSB first; tdo is captured while tde is high.
//  Sits between the on-chip test controller and the TAP pins; replaces the bench-only task-based master.
// PARAMETERS
//  KEY_W    8      unlock key width; must be <= CFG_W
//  KEY      8'h96  key shifted by ENTER
//  CFG_W    8      config/RAW word width; ENTER uses {length[4:0],mode[2:0]} when 8
//  HALF     50     tck high time in clk cycles; bit period = 2*HALF; HALF >= 2
//  SETUP    4      clk cycles from tdi update to tck rise; 1 <= SETUP < HALF
//  RST_BITS 4      bit periods with trstb low in the reset phase
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous active-high reset
//  cmd_valid  in   1      command request
//  cmd_ready  out  1      high only in IDLE and not in reset
//  cmd_op     in   2      00 RESET, 01 SETKEY, 10 ENTER, 11 RAW
//  cmd_data   in   CFG_W  SETKEY: key = [KEY_W-1:0]; ENTER: config word; RAW: shift word
//  busy       out  1      sequence in progress
//  done       out  1      one-cycle pulse at the end of a sequence
//  rsp_data   out  CFG_W  captured tdo bits; valid with done, held until the next accept
//  tdo        in   1      TAP data out (synchronised externally)
//  tde        in   1      tdo valid qualifier
//  tdi        out  1      TAP data in
//  tck        out  1      TAP clock
//  trstb      out  1      TAP reset, active low
// BEHAVIOUR
//  Reset values: tdi=0, tck=0, trstb=0, busy=0, done=0, rsp_data=0, cmd_ready=0 while rst is high.
//  rst is honoured in any state. The next edge forces the reset values, so a sequence is aborted mid-bit.
//  trstb stays 0 after reset until the first reset phase completes.
//  Accept: cmd_valid & cmd_ready on an edge. Latch op/data, clear rsp_data, and go busy on the next cycle.
//  cmd_valid while busy is ignored. No queueing.
//  Bit cell of 2*HALF cycles, counted c = 0 .. 2*HALF-1:
//   c=0 tdi <= bit; c=SETUP tck <= 1; c=SETUP+HALF tck <= 0. tck idles at 0 between commands.
//  Capture: on the cycle tck goes 1, if tde=1 then rsp_data <= {rsp_data[CFG_W-2:0], tdo}.
//   With tde=0 there is no shift.
//  FSM: IDLE -> RSTP -> KEYP -> CFGP -> TAIL -> FIN -> IDLE.
//   RSTP: RST_BITS cells, tdi=0, trstb=0 from c=0 of the first cell. At the end of the last cell, trstb <= 1.
//   KEYP: KEY_W cells. SETKEY sends cmd_data[KEY_W-1:0]; ENTER sends KEY.
//   CFGP: CFG_W cells of cmd_data.
//   TAIL: one cell with tdi=0.
//   FIN: done=1 for one cycle, tdi <= 0, then IDLE. busy drops with done.
//  Phase sequence per op:
//   RESET:  RSTP -> FIN
//   SETKEY: RSTP -> KEYP -> TAIL -> FIN
//   ENTER:  RSTP -> KEYP -> CFGP -> TAIL -> FIN
//   RAW:    CFGP -> FIN; trstb is left unchanged.
//  Accept-to-done latency: 1 + (number of cells)*2*HALF + 1 cycles. done and cmd_ready are high in the same cycle.
//  A new command is accepted on the done cycle and starts its first cell on the next cycle.
//  Counters: cell counter wraps at 2*HALF-1. Bit index counts down from width-1 to 0; reaching 0 ends the phase.
// TESTING (HALF=4, SETUP=1, defaults otherwise)
//  ENTER cmd_data=8'h0A -> trstb=0 for 32 clk. tdi bits 0000,10010110,00001010,0. done at 170 clk after accept.
//  SETKEY cmd_data=8'h5A -> trstb=0 for 4 cells, then tdi 01011010,0. 13 cells. done at 106 clk. trstb=1 after.
//  RAW 8'hFF, tde=1, tdo pattern 1,1,0,0,0,0,1,1 -> rsp_data=8'hC3, trstb unchanged, done at 66 clk.
//   With tde=0 throughout -> rsp_data=0.
//  cmd_valid held during busy -> ignored. Back-to-back RESET accepted on the done cycle -> second done 34 clk later.
//  rst pulsed during KEYP bit 3 -> next edge tck=0, tdi=0, trstb=0, busy=0. The following ENTER runs a full sequence.
//  Each cell: tdi stable from SETUP cycles before tck rise through tck fall. tck high exactly HALF cycles.

Source files
------------

// File: rtl/tap_master_ctrl.sv
// TAP master sequencer: turns RESET/SETKEY/ENTER/RAW commands into bit-serial tdi/tck/trstb
// activity, MSB first, and captures tdo into rsp_data while tde is high.
module tap_master_ctrl #(
    parameter int unsigned       KEY_W    = 8,
    parameter logic [KEY_W-1:0]  KEY      = 8'h96,
    parameter int unsigned       CFG_W    = 8,
    parameter int unsigned       HALF     = 50,
    parameter int unsigned       SETUP    = 4,
    parameter int unsigned       RST_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CFG_W-1:0] cmd_data,
    output logic             busy,
    output logic             done,
    output logic [CFG_W-1:0] rsp_data,
    input  logic             tdo,
    input  logic             tde,
    output logic             tdi,
    output logic             tck,
    output logic             trstb
);

    localparam int unsigned PERIOD = 2 * HALF;
    localparam int unsigned CW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int unsigned MAXW   = (RST_BITS > KEY_W) ?
                                     ((RST_BITS > CFG_W) ? RST_BITS : CFG_W) :
                                     ((KEY_W > CFG_W) ? KEY_W : CFG_W);
    localparam int unsigned IW     = (MAXW > 2) ? $clog2(MAXW) : 1;

    localparam logic [1:0] OpReset  = 2'b00;
    localparam logic [1:0] OpSetkey = 2'b01;
    localparam logic [1:0] OpEnter  = 2'b10;
    localparam logic [1:0] OpRaw    = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRstp,
        StKeyp,
        StCfgp,
        StTail,
        StFin
    } state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic [KEY_W-1:0] key_sh_q;
    logic [CFG_W-1:0] cfg_sh_q;

    assign cmd_ready = (state_q == StIdle) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpReset;
            cnt_q    <= '0;
            idx_q    <= '0;
            key_sh_q <= '0;
            cfg_sh_q <= '0;
            tdi      <= 1'b0;
            tck      <= 1'b0;
            trstb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rsp_data <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        cfg_sh_q <= cmd_data;
                        key_sh_q <= (cmd_op == OpSetkey) ? cmd_data[KEY_W-1:0] : KEY;
                        rsp_data <= '0;
                        busy     <= 1'b1;
                        cnt_q    <= '0;
                        if (cmd_op == OpRaw) begin
                            state_q <= StCfgp;
                            idx_q   <= IW'(CFG_W - 1);
                        end else begin
                            // trstb is already low during c=0 of the first reset cell
                            trstb   <= 1'b0;
                            state_q <= StRstp;
                            idx_q   <= IW'(RST_BITS - 1);
                        end
                    end
                end

                StRstp, StKeyp, StCfgp, StTail: begin
                    if (cnt_q == '0) begin
                        case (state_q)
                            StRstp: begin
                                tdi   <= 1'b0;
                                trstb <= 1'b0;
                            end
                            StKeyp: begin
                                tdi      <= key_sh_q[KEY_W-1];
                                key_sh_q <= key_sh_q << 1;
                            end
                            StCfgp: begin
                                tdi      <= cfg_sh_q[CFG_W-1];
                                cfg_sh_q <= cfg_sh_q << 1;
                            end
                            default: tdi <= 1'b0;
                        endcase
                    end

                    if (cnt_q == CW'(SETUP)) begin
                        tck <= 1'b1;
                        if (tde) begin
                            rsp_data <= (rsp_data << 1) | CFG_W'(tdo);
                        end
                    end

                    if (cnt_q == CW'(SETUP + HALF)) begin
                        tck <= 1'b0;
                    end

                    if (cnt_q == CW'(PERIOD - 1)) begin
                        cnt_q <= '0;
                        if (idx_q == '0) begin
                            case (state_q)
                                StRstp: begin
                                    trstb <= 1'b1;
                                    if (op_q == OpReset) begin
                                        state_q <= StFin;
                                    end else begin
                                        state_q <= StKeyp;
                                        idx_q   <= IW'(KEY_W - 1);
                                    end
                                end
                                StKeyp: begin
                                    if (op_q == OpEnter) begin
                                        state_q <= StCfgp;
                                        idx_q   <= IW'(CFG_W - 1);
                                    end else begin
                                        state_q <= StTail;
                                        idx_q   <= '0;
                                    end
                                end
                                StCfgp: begin
                                    if (op_q == OpRaw) begin
                                        state_q <= StFin;
                                    end else begin
                                        state_q <= StTail;
                                        idx_q   <= '0;
                                    end
                                end
                                default: state_q <= StFin;
                            endcase
                        end else begin
                            idx_q <= idx_q - 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StFin: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    tdi     <= 1'b0;
                    state_q <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_master_ctrl.sv
// Directed bench for tap_master_ctrl with HALF=4, SETUP=1: table of whole commands plus
// hand-written back-to-back and abort sequences.
module tb_tap_master_ctrl;

    localparam int HALF  = 4;
    localparam int SETUP = 1;

    localparam logic [1:0] OP_RESET  = 2'b00;
    localparam logic [1:0] OP_SETKEY = 2'b01;
    localparam logic [1:0] OP_ENTER  = 2'b10;
    localparam logic [1:0] OP_RAW    = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] rsp_data;
    logic       tdo = 1'b0;
    logic       tde = 1'b0;
    logic       tdi;
    logic       tck;
    logic       trstb;

    int checks = 0;
    int errors = 0;

    tap_master_ctrl #(
        .HALF  (HALF),
        .SETUP (SETUP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .done      (done),
        .rsp_data  (rsp_data),
        .tdo       (tdo),
        .tde       (tde),
        .tdi       (tdi),
        .tck       (tck),
        .trstb     (trstb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  data;
        logic        tde;
        logic [7:0]  pat;
        int          lat;
        int          nbits;
        logic [31:0] bits;
        int          tlow;
        logic [7:0]  rsp;
        logic        trst_end;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for cmd_ready, present a command and let the accept edge pass.
    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_issue", {63'd0, cmd_ready}, 64'd1);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the accept edge; counts cycles to done and records the tdi stream.
    task automatic monitor(input bit keep_valid, input logic [7:0] pat,
                           output int lat, output int nbits, output logic [31:0] bits,
                           output int tlow, output int tck_bad, output logic [7:0] rsp,
                           output logic trst_end, output logic rdy_end, output logic busy_end);
        int   n = 0;
        int   hi = 0;
        int   since = 0;
        int   k = 0;
        logic tck_prev = 1'b0;
        logic tdi_prev;
        logic chg;
        logic [7:0] p;
        p = pat;
        lat = -1; nbits = 0; bits = '0; tlow = 0; tck_bad = 0;
        rsp = '0; trst_end = 1'b0; rdy_end = 1'b0; busy_end = 1'b1;
        tdi_prev = tdi;
        tdo = p[7];
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) cmd_valid = keep_valid;
            chg = (tdi != tdi_prev);
            if (chg) since = 0; else since++;
            if (tck && !tck_prev) begin
                bits = {bits[30:0], tdi};
                nbits++;
                hi = 1;
                if (since < SETUP) tck_bad++;
            end else if (tck) begin
                hi++;
                if (chg) tck_bad++;
            end else if (tck_prev) begin
                if (hi != HALF) tck_bad++;
                k++;
                if (k < 8) tdo = p[7-k];
            end
            if (!trstb) tlow++;
            tdi_prev = tdi;
            tck_prev = tck;
            if (done) begin
                lat      = n;
                rsp      = rsp_data;
                trst_end = trstb;
                rdy_end  = cmd_ready;
                busy_end = busy;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, nbits, tlow, tck_bad;
        logic [31:0] bits;
        logic [7:0] rsp;
        logic trst_end, rdy_end, busy_end;
        tde = v.tde;
        issue(v.op, v.data);
        monitor(1'b0, v.pat, lat, nbits, bits, tlow, tck_bad, rsp, trst_end, rdy_end, busy_end);
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        check({tag, "_nbits"}, 64'(nbits), 64'(v.nbits));
        check({tag, "_tdi_bits"}, 64'(bits), 64'(v.bits));
        check({tag, "_trstb_low"}, 64'(tlow), 64'(v.tlow));
        check({tag, "_tck_timing"}, 64'(tck_bad), 64'd0);
        check({tag, "_rsp"}, 64'(rsp), 64'(v.rsp));
        check({tag, "_trstb_end"}, {63'd0, trst_end}, {63'd0, v.trst_end});
        check({tag, "_ready_busy_at_done"}, {62'd0, rdy_end, busy_end}, 64'd2);
    endtask

    initial begin
        int lat, nbits, tlow, tck_bad;
        logic [31:0] bits;
        logic [7:0] rsp;
        logic trst_end, rdy_end, busy_end;
        vec_t v;

        vecs[0] = '{OP_RESET,  8'h00, 1'b0, 8'h00, 34,  4,  32'h0, 32, 8'h00, 1'b1};
        vecs[1] = '{OP_ENTER,  8'h0A, 1'b0, 8'h00, 170, 21,
                    {11'd0, 4'd0, 8'h96, 8'h0A, 1'b0}, 32, 8'h00, 1'b1};
        vecs[2] = '{OP_SETKEY, 8'h5A, 1'b0, 8'h00, 106, 13,
                    {19'd0, 4'd0, 8'h5A, 1'b0}, 32, 8'h00, 1'b1};
        vecs[3] = '{OP_RAW,    8'hFF, 1'b1, 8'hC3, 66,  8,  {24'd0, 8'hFF}, 0, 8'hC3, 1'b1};
        vecs[4] = '{OP_RAW,    8'hA5, 1'b0, 8'hFF, 66,  8,  {24'd0, 8'hA5}, 0, 8'h00, 1'b1};
        vecs[5] = '{OP_ENTER,  8'h3C, 1'b1, 8'hFF, 170, 21,
                    {11'd0, 4'd0, 8'h96, 8'h3C, 1'b0}, 32, 8'hFF, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {58'd0, tdi, tck, trstb, busy, done, cmd_ready}, 64'd0);
        check("reset_rsp", 64'(rsp_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {62'd0, cmd_ready, trstb}, 64'd2);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // cmd_valid held through busy: ignored, then taken on the done cycle
        tde = 1'b0;
        issue(OP_RESET, 8'h00);
        monitor(1'b1, 8'h00, lat, nbits, bits, tlow, tck_bad, rsp, trst_end, rdy_end, busy_end);
        check("b2b_first_latency", 64'(lat), 64'd34);
        check("b2b_ready_at_done", {63'd0, rdy_end}, 64'd1);
        @(posedge clk);
        monitor(1'b0, 8'h00, lat, nbits, bits, tlow, tck_bad, rsp, trst_end, rdy_end, busy_end);
        check("b2b_second_latency", 64'(lat), 64'd34);
        check("b2b_second_nbits", 64'(nbits), 64'd4);

        // rst in the middle of the key phase
        issue(OP_ENTER, 8'h0A);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 1'b0;
        end
        check("abort_precond", {60'd0, tck, tdi, trstb, busy}, 64'hF);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {58'd0, tck, tdi, trstb, busy, done, cmd_ready}, 64'd0);
        rst = 1'b0;
        v = vecs[1];
        run_vec(v, "post_abort_enter");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
